// File: rtl/riscv_wb_arbiter_pkg.sv
// Shared types and defaults for the register-file writeback arbiter.
// The global macros normally come from riscv_configs.v (XLEN, RF_ADDR_W and
// the arbiter defaults). The guarded fallbacks below keep this slice
// buildable on its own when that file has not been read first.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef RF_ADDR_W
`define RF_ADDR_W 5
`endif
`ifndef WB_ARB_DEPTH
`define WB_ARB_DEPTH 4
`endif
`ifndef WB_ARB_STARVE_LIMIT
`define WB_ARB_STARVE_LIMIT 4
`endif

package riscv_wb_arbiter_pkg;
   localparam int XLEN             = `XLEN;
   localparam int RF_ADDR_W        = `RF_ADDR_W;
   localparam int DEF_DEPTH        = `WB_ARB_DEPTH;
   localparam int DEF_STARVE_LIMIT = `WB_ARB_STARVE_LIMIT;

   // One buffered aux result: destination register plus value.
   typedef struct packed {
      logic [RF_ADDR_W-1:0] rd;
      logic [XLEN-1:0]      data;
   } wb_entry_t;

   localparam int ENTRY_W = $bits(wb_entry_t);

   // True when a decode-stage address is live (nonzero) and names rd.
   function automatic logic addr_hit(input logic [RF_ADDR_W-1:0] rd,
                                     input logic [RF_ADDR_W-1:0] dec_addr);
      return (dec_addr != '0) && (rd == dec_addr);
   endfunction
endpackage

// File: rtl/riscv_wb_fifo.sv
// Synchronous FIFO holding aux results waiting for the register-file port.
// Exposes occupancy plus per-entry valid/rd vectors so the top level can
// compare pending destinations against decode-stage operands.
// Callers never push when full nor pop when empty.
module riscv_wb_fifo
   import riscv_wb_arbiter_pkg::*;
#(
   parameter int DEPTH = DEF_DEPTH
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                push,
   input  wb_entry_t                           push_entry,
   input  logic                                pop,
   output wb_entry_t                           head,
   output logic [$clog2(DEPTH):0]              count,
   output logic [DEPTH-1:0]                    entry_valid,
   output logic [DEPTH-1:0][RF_ADDR_W-1:0]     entry_rd
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   wb_entry_t        mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    count_q;
   logic [DEPTH-1:0] valid_q;

   // Storage array: written only on push, never reset (valid bits gate it).
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= push_entry;
      end
   end

   // Pointers, occupancy and per-slot valid bits; pointers wrap naturally.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
         valid_q <= '0;
      end else begin
         if (pop) begin
            rd_ptr          <= rd_ptr + AW'(1);
            valid_q[rd_ptr] <= 1'b0;
         end
         if (push) begin
            wr_ptr          <= wr_ptr + AW'(1);
            valid_q[wr_ptr] <= 1'b1;
         end
         case ({push, pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Per-entry destination addresses for the hazard comparators.
   always_comb begin
      entry_rd = '0;
      for (int i = 0; i < DEPTH; i++) begin
         entry_rd[i] = mem[i].rd;
      end
   end

   assign head        = mem[rd_ptr];
   assign count       = count_q;
   assign entry_valid = valid_q;
endmodule

// File: rtl/riscv_wb_arbiter.sv
// Register-file write-port arbiter between the pipeline W stage and a
// buffered long-latency aux source. Pipeline writes win unless the aux FIFO
// head has lost STARVE_LIMIT times in a row, in which case W is stalled.
// Optional macro RISCV_WB_ARB_HAZARD_EN adds decode-stage hazard detection
// against pending aux destinations.
// Handshake: an aux transfer happens on a cycle where i_aux_valid and
// o_aux_ready are both high; o_aux_ready depends on registered occupancy
// only, and the source must hold valid and payload until that cycle.
module riscv_wb_arbiter
   import riscv_wb_arbiter_pkg::*;
#(
   parameter int DEPTH        = DEF_DEPTH,
   parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_wb_we,
   input  logic [RF_ADDR_W-1:0]     i_wb_rd_addr,
   input  logic [XLEN-1:0]          i_wb_rd_data,
   output logic                     o_wb_stall,
   input  logic                     i_aux_valid,
   output logic                     o_aux_ready,
   input  logic [RF_ADDR_W-1:0]     i_aux_rd_addr,
   input  logic [XLEN-1:0]          i_aux_rd_data,
`ifdef RISCV_WB_ARB_HAZARD_EN
   input  logic [RF_ADDR_W-1:0]     i_rs1_addrD,
   input  logic [RF_ADDR_W-1:0]     i_rs2_addrD,
   input  logic [RF_ADDR_W-1:0]     i_rd_addrD,
   output logic                     o_aux_hazard,
`endif
   output logic                     o_rf_we,
   output logic [RF_ADDR_W-1:0]     o_rf_rd_addr,
   output logic [XLEN-1:0]          o_rf_rd_data,
   output logic [$clog2(DEPTH):0]   o_aux_count
);
   localparam int CW = $clog2(DEPTH) + 1;
   localparam int SW = $clog2(STARVE_LIMIT + 1);
   localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

   wb_entry_t                       head;
   wb_entry_t                       push_entry;
   logic [CW-1:0]                   count;
   logic [DEPTH-1:0]                entry_valid;
   logic [DEPTH-1:0][RF_ADDR_W-1:0] entry_rd;
   logic [SW-1:0]                   starve_cnt;

   logic wb_req;
   logic head_v;
   logic grant_aux;
   logic grant_wb;
   logic aux_ready;
   logic push;

   // Grant decision; everything is forced idle while reset is asserted.
   always_comb begin
      wb_req    = i_wb_we && (i_wb_rd_addr != '0);
      head_v    = (count != '0);
      grant_aux = !i_rst && head_v && (!wb_req || (starve_cnt == STARVE_MAX));
      grant_wb  = !i_rst && wb_req && !grant_aux;
      aux_ready = !i_rst && (count < CW'(DEPTH));
      // rd=0 results are accepted but dropped rather than stored.
      push      = i_aux_valid && aux_ready && (i_aux_rd_addr != '0);
   end

   assign push_entry = '{rd: i_aux_rd_addr, data: i_aux_rd_data};

   riscv_wb_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk         (i_clk),
      .rst         (i_rst),
      .push        (push),
      .push_entry  (push_entry),
      .pop         (grant_aux),
      .head        (head),
      .count       (count),
      .entry_valid (entry_valid),
      .entry_rd    (entry_rd)
   );

   // Write-port mux driven directly by the grant.
   always_comb begin
      o_rf_we      = 1'b0;
      o_rf_rd_addr = '0;
      o_rf_rd_data = '0;
      if (grant_aux) begin
         o_rf_we      = 1'b1;
         o_rf_rd_addr = head.rd;
         o_rf_rd_data = head.data;
      end else if (grant_wb) begin
         o_rf_we      = 1'b1;
         o_rf_rd_addr = i_wb_rd_addr;
         o_rf_rd_data = i_wb_rd_data;
      end
   end

   // Counts consecutive losses of a valid head; saturates at the limit.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         starve_cnt <= '0;
      end else if (!head_v || grant_aux) begin
         starve_cnt <= '0;
      end else if (grant_wb && (starve_cnt != STARVE_MAX)) begin
         starve_cnt <= starve_cnt + SW'(1);
      end
   end

   assign o_wb_stall  = wb_req && grant_aux;
   assign o_aux_ready = aux_ready;
   assign o_aux_count = count;

`ifdef RISCV_WB_ARB_HAZARD_EN
   // Flags any pending or currently-accepted aux destination that matches
   // a live decode-stage register address.
   always_comb begin
      o_aux_hazard = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (entry_valid[i] && (addr_hit(entry_rd[i], i_rs1_addrD) ||
                                addr_hit(entry_rd[i], i_rs2_addrD) ||
                                addr_hit(entry_rd[i], i_rd_addrD))) begin
            o_aux_hazard = 1'b1;
         end
      end
      if (push && (addr_hit(i_aux_rd_addr, i_rs1_addrD) ||
                   addr_hit(i_aux_rd_addr, i_rs2_addrD) ||
                   addr_hit(i_aux_rd_addr, i_rd_addrD))) begin
         o_aux_hazard = 1'b1;
      end
      if (i_rst) begin
         o_aux_hazard = 1'b0;
      end
   end
`else
   // Per-entry information only feeds the optional hazard comparators.
   logic unused_entry_info;
   assign unused_entry_info = ^{entry_valid, entry_rd};
`endif
endmodule

// File: tb/tb_riscv_wb_arbiter.sv
// Bench for riscv_wb_arbiter: directed scenarios plus randomized traffic,
// all checked against a queue-based reference model of the write port.
module tb_riscv_wb_arbiter;
   import riscv_wb_arbiter_pkg::*;

   localparam int DEPTH        = 4;
   localparam int STARVE_LIMIT = 4;
   localparam int CW           = $clog2(DEPTH) + 1;

   logic             clk = 1'b0;
   logic             i_rst;
   logic             i_wb_we;
   logic [4:0]       i_wb_rd_addr;
   logic [XLEN-1:0]  i_wb_rd_data;
   logic             o_wb_stall;
   logic             i_aux_valid;
   logic             o_aux_ready;
   logic [4:0]       i_aux_rd_addr;
   logic [XLEN-1:0]  i_aux_rd_data;
   logic             o_rf_we;
   logic [4:0]       o_rf_rd_addr;
   logic [XLEN-1:0]  o_rf_rd_data;
   logic [CW-1:0]    o_aux_count;
`ifdef RISCV_WB_ARB_HAZARD_EN
   logic [4:0]       i_rs1_addrD;
   logic [4:0]       i_rs2_addrD;
   logic [4:0]       i_rd_addrD;
   logic             o_aux_hazard;
   logic             obs_haz;
`endif

   // Reference model state: pending aux results in acceptance order.
   logic [ENTRY_W-1:0] exp_q[$];
   int lose_cnt;
   int checks = 0;
   int errors = 0;

   logic             obs_we, obs_stall, obs_ready;
   logic [4:0]       obs_addr;
   logic [XLEN-1:0]  obs_data;
   logic [CW-1:0]    obs_cnt;

   // Clock / reset block
   always #5 clk = ~clk;

   riscv_wb_arbiter #(
      .DEPTH        (DEPTH),
      .STARVE_LIMIT (STARVE_LIMIT)
   ) dut (
      .i_clk         (clk),
      .i_rst         (i_rst),
      .i_wb_we       (i_wb_we),
      .i_wb_rd_addr  (i_wb_rd_addr),
      .i_wb_rd_data  (i_wb_rd_data),
      .o_wb_stall    (o_wb_stall),
      .i_aux_valid   (i_aux_valid),
      .o_aux_ready   (o_aux_ready),
      .i_aux_rd_addr (i_aux_rd_addr),
      .i_aux_rd_data (i_aux_rd_data),
`ifdef RISCV_WB_ARB_HAZARD_EN
      .i_rs1_addrD   (i_rs1_addrD),
      .i_rs2_addrD   (i_rs2_addrD),
      .i_rd_addrD    (i_rd_addrD),
      .o_aux_hazard  (o_aux_hazard),
`endif
      .o_rf_we       (o_rf_we),
      .o_rf_rd_addr  (o_rf_rd_addr),
      .o_rf_rd_data  (o_rf_rd_data),
      .o_aux_count   (o_aux_count)
   );

   task automatic model_clear();
      exp_q.delete();
      lose_cnt = 0;
   endtask

   // Drives one cycle of inputs, checks outputs mid-cycle against the
   // model, then advances the model across the rising edge.
   task automatic step(input logic we, input logic [4:0] wa, input logic [XLEN-1:0] wd,
                       input logic av, input logic [4:0] aa, input logic [XLEN-1:0] ad);
      logic wb_req, head, aux_win, wb_win, e_we, e_stall, e_ready;
      logic [4:0] e_addr;
      logic [XLEN-1:0] e_data;
      logic [CW-1:0] e_cnt;
`ifdef RISCV_WB_ARB_HAZARD_EN
      logic e_haz;
      logic [4:0] r;
`endif
      i_wb_we = we; i_wb_rd_addr = wa; i_wb_rd_data = wd;
      i_aux_valid = av; i_aux_rd_addr = aa; i_aux_rd_data = ad;
      #4;
      wb_req  = we && (wa != 0);
      head    = (exp_q.size() != 0);
      aux_win = head && (!wb_req || (lose_cnt >= STARVE_LIMIT));
      wb_win  = wb_req && !aux_win;
      e_ready = (exp_q.size() < DEPTH);
      e_we    = aux_win || wb_win;
      e_stall = wb_req && aux_win;
      e_cnt   = CW'(exp_q.size());
      e_addr  = '0;
      e_data  = '0;
      if (aux_win) begin
         e_addr = exp_q[0][ENTRY_W-1 -: 5];
         e_data = exp_q[0][XLEN-1:0];
      end else if (wb_win) begin
         e_addr = wa;
         e_data = wd;
      end
      checks++; if (o_rf_we !== e_we) begin errors++; $display("FAIL rf_we t=%0t got %b exp %b", $time, o_rf_we, e_we); end
      checks++; if (o_rf_rd_addr !== e_addr) begin errors++; $display("FAIL rf_addr t=%0t got %0d exp %0d", $time, o_rf_rd_addr, e_addr); end
      checks++; if (o_rf_rd_data !== e_data) begin errors++; $display("FAIL rf_data t=%0t got %h exp %h", $time, o_rf_rd_data, e_data); end
      checks++; if (o_wb_stall !== e_stall) begin errors++; $display("FAIL wb_stall t=%0t got %b exp %b", $time, o_wb_stall, e_stall); end
      checks++; if (o_aux_ready !== e_ready) begin errors++; $display("FAIL aux_ready t=%0t got %b exp %b", $time, o_aux_ready, e_ready); end
      checks++; if (o_aux_count !== e_cnt) begin errors++; $display("FAIL aux_count t=%0t got %0d exp %0d", $time, o_aux_count, e_cnt); end
`ifdef RISCV_WB_ARB_HAZARD_EN
      e_haz = 1'b0;
      for (int i = 0; i < exp_q.size(); i++) begin
         r = exp_q[i][ENTRY_W-1 -: 5];
         if ((i_rs1_addrD != 0 && r == i_rs1_addrD) || (i_rs2_addrD != 0 && r == i_rs2_addrD) ||
             (i_rd_addrD != 0 && r == i_rd_addrD)) e_haz = 1'b1;
      end
      if (av && e_ready && ((i_rs1_addrD != 0 && aa == i_rs1_addrD) || (i_rs2_addrD != 0 && aa == i_rs2_addrD) ||
                            (i_rd_addrD != 0 && aa == i_rd_addrD))) e_haz = 1'b1;
      checks++; if (o_aux_hazard !== e_haz) begin errors++; $display("FAIL aux_hazard t=%0t got %b exp %b", $time, o_aux_hazard, e_haz); end
      obs_haz = o_aux_hazard;
`endif
      obs_we = o_rf_we; obs_stall = o_wb_stall; obs_ready = o_aux_ready;
      obs_addr = o_rf_rd_addr; obs_data = o_rf_rd_data; obs_cnt = o_aux_count;
      @(posedge clk);
      if (aux_win) void'(exp_q.pop_front());
      if (av && e_ready && aa != 0) exp_q.push_back({aa, ad});
      if (!head || aux_win) lose_cnt = 0;
      else if (wb_win) lose_cnt = (lose_cnt + 1 > STARVE_LIMIT) ? STARVE_LIMIT : lose_cnt + 1;
      #1;
   endtask

   task automatic step_idle();
      step(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
   endtask

   // Holds reset for one edge with busy inputs; every output must be 0.
   task automatic pulse_reset(input string tag);
      i_rst = 1'b1;
      i_wb_we = 1'b1; i_wb_rd_addr = 5'd5; i_wb_rd_data = 'h55;
      i_aux_valid = 1'b1; i_aux_rd_addr = 5'd6; i_aux_rd_data = 'h66;
      #4;
      checks++; if (o_rf_we !== 1'b0) begin errors++; $display("FAIL %s rf_we got %b exp 0", tag, o_rf_we); end
      checks++; if (o_wb_stall !== 1'b0) begin errors++; $display("FAIL %s stall got %b exp 0", tag, o_wb_stall); end
      checks++; if (o_aux_ready !== 1'b0) begin errors++; $display("FAIL %s ready got %b exp 0", tag, o_aux_ready); end
      checks++; if (o_rf_rd_addr !== 5'd0) begin errors++; $display("FAIL %s addr got %0d exp 0", tag, o_rf_rd_addr); end
      checks++; if (o_rf_rd_data !== '0) begin errors++; $display("FAIL %s data got %h exp 0", tag, o_rf_rd_data); end
      checks++; if (o_aux_count !== '0) begin errors++; $display("FAIL %s count got %0d exp 0", tag, o_aux_count); end
`ifdef RISCV_WB_ARB_HAZARD_EN
      checks++; if (o_aux_hazard !== 1'b0) begin errors++; $display("FAIL %s hazard got %b exp 0", tag, o_aux_hazard); end
`endif
      @(posedge clk);
      #1;
      i_rst = 1'b0;
      model_clear();
   endtask

   task automatic test_reset();
      pulse_reset("reset");
      step_idle();
      checks++; if (obs_we !== 1'b0 || obs_cnt !== '0) begin errors++; $display("FAIL idle we=%b cnt=%0d exp 0/0", obs_we, obs_cnt); end
   endtask

   task automatic test_pipeline();
      step(1'b1, 5'd5, 'h11, 1'b0, 5'd0, '0);
      checks++; if (obs_we !== 1'b1 || obs_addr !== 5'd5 || obs_data !== 'h11 || obs_stall !== 1'b0) begin
         errors++; $display("FAIL pipe_write we=%b addr=%0d data=%h stall=%b exp 1/5/11/0", obs_we, obs_addr, obs_data, obs_stall);
      end
      step(1'b1, 5'd0, 'h22, 1'b0, 5'd0, '0);
      checks++; if (obs_we !== 1'b0 || obs_stall !== 1'b0) begin errors++; $display("FAIL pipe_x0 we=%b stall=%b exp 0/0", obs_we, obs_stall); end
   endtask

   task automatic test_aux_idle();
      step(1'b0, 5'd0, '0, 1'b1, 5'd7, 'hAA);
      checks++; if (obs_we !== 1'b0) begin errors++; $display("FAIL aux_bypass we=%b exp 0", obs_we); end
      step_idle();
      checks++; if (obs_we !== 1'b1 || obs_addr !== 5'd7 || obs_data !== 'hAA) begin
         errors++; $display("FAIL aux_write we=%b addr=%0d data=%h exp 1/7/aa", obs_we, obs_addr, obs_data);
      end
      step_idle();
      checks++; if (obs_cnt !== '0) begin errors++; $display("FAIL aux_drain cnt=%0d exp 0", obs_cnt); end
   endtask

   task automatic test_starvation();
      step(1'b0, 5'd0, '0, 1'b1, 5'd3, 'h33);
      for (int c = 1; c <= STARVE_LIMIT; c++) begin
         step(1'b1, 5'd5, XLEN'(c), 1'b0, 5'd0, '0);
         checks++; if (obs_stall !== 1'b0 || obs_addr !== 5'd5) begin errors++; $display("FAIL starve_win%0d stall=%b addr=%0d exp 0/5", c, obs_stall, obs_addr); end
      end
      step(1'b1, 5'd5, 'h99, 1'b0, 5'd0, '0);
      checks++; if (obs_stall !== 1'b1 || obs_addr !== 5'd3) begin errors++; $display("FAIL starve_force stall=%b addr=%0d exp 1/3", obs_stall, obs_addr); end
      step(1'b1, 5'd5, 'h99, 1'b0, 5'd0, '0);
      checks++; if (obs_stall !== 1'b0 || obs_addr !== 5'd5 || obs_data !== 'h99) begin
         errors++; $display("FAIL starve_held stall=%b addr=%0d data=%h exp 0/5/99", obs_stall, obs_addr, obs_data);
      end
   endtask

   task automatic test_full();
      logic [4:0] order [5];
      order[0] = 5'd10; order[1] = 5'd11; order[2] = 5'd12; order[3] = 5'd13; order[4] = 5'd21;
      for (int i = 0; i < 4; i++) step(1'b1, 5'd5, 'h1, 1'b1, order[i], XLEN'(i));
      step(1'b1, 5'd5, 'h1, 1'b1, 5'd20, 'h20);
      checks++; if (obs_ready !== 1'b0 || obs_cnt !== CW'(4)) begin errors++; $display("FAIL full ready=%b cnt=%0d exp 0/4", obs_ready, obs_cnt); end
      step(1'b1, 5'd5, 'h1, 1'b1, 5'd20, 'h20);
      checks++; if (obs_addr !== order[0]) begin errors++; $display("FAIL order0 addr=%0d exp %0d", obs_addr, order[0]); end
      step(1'b0, 5'd0, '0, 1'b1, 5'd21, 'h21);
      checks++; if (obs_addr !== order[1] || obs_cnt !== CW'(3)) begin errors++; $display("FAIL pushpop addr=%0d cnt=%0d exp %0d/3", obs_addr, obs_cnt, order[1]); end
      for (int i = 2; i < 5; i++) begin
         step_idle();
         checks++; if (obs_addr !== order[i]) begin errors++; $display("FAIL order%0d addr=%0d exp %0d", i, obs_addr, order[i]); end
         if (i == 2) begin
            checks++; if (obs_cnt !== CW'(3)) begin errors++; $display("FAIL pushpop_cnt cnt=%0d exp 3", obs_cnt); end
         end
      end
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 3; i++) step(1'b1, 5'd5, 'h7, 1'b1, 5'(i + 1), 'h70);
      pulse_reset("reset_mid");
      for (int i = 0; i < 2; i++) begin
         step_idle();
         checks++; if (obs_we !== 1'b0 || obs_cnt !== '0) begin errors++; $display("FAIL flush we=%b cnt=%0d exp 0/0", obs_we, obs_cnt); end
      end
   endtask

`ifdef RISCV_WB_ARB_HAZARD_EN
   task automatic test_hazard();
      i_rs1_addrD = 5'd0; i_rs2_addrD = 5'd9; i_rd_addrD = 5'd0;
      step(1'b1, 5'd5, 'h1, 1'b1, 5'd9, 'h9);
      step(1'b1, 5'd5, 'h1, 1'b0, 5'd0, '0);
      checks++; if (obs_haz !== 1'b1) begin errors++; $display("FAIL hazard_hit got %b exp 1", obs_haz); end
      step_idle();
      step_idle();
      checks++; if (obs_haz !== 1'b0) begin errors++; $display("FAIL hazard_popped got %b exp 0", obs_haz); end
      i_rs2_addrD = 5'd0;
      step(1'b0, 5'd0, '0, 1'b1, 5'd0, 'h5);
      checks++; if (obs_haz !== 1'b0) begin errors++; $display("FAIL hazard_x0 got %b exp 0", obs_haz); end
   endtask
`endif

   task automatic test_random();
      logic we, av;
      logic [4:0] wa, aa;
      for (int n = 0; n < 400; n++) begin
         we = ($urandom_range(0, 3) != 0);
         wa = 5'($urandom_range(0, 31));
         if ($urandom_range(0, 7) == 0) wa = 5'd0;
         av = ($urandom_range(0, 1) == 1);
         aa = 5'($urandom_range(0, 31));
`ifdef RISCV_WB_ARB_HAZARD_EN
         i_rs1_addrD = 5'($urandom_range(0, 31));
         i_rs2_addrD = 5'($urandom_range(0, 31));
         i_rd_addrD  = 5'($urandom_range(0, 31));
`endif
         step(we, wa, XLEN'($urandom()), av, aa, XLEN'($urandom()));
      end
   endtask

   initial begin
      i_rst = 1'b1;
      i_wb_we = 1'b0; i_wb_rd_addr = '0; i_wb_rd_data = '0;
      i_aux_valid = 1'b0; i_aux_rd_addr = '0; i_aux_rd_data = '0;
`ifdef RISCV_WB_ARB_HAZARD_EN
      i_rs1_addrD = '0; i_rs2_addrD = '0; i_rd_addrD = '0;
`endif
      model_clear();
      @(posedge clk);
      #1;
      test_reset();
      test_pipeline();
      test_aux_idle();
      test_starvation();
      test_full();
      test_reset_mid();
`ifdef RISCV_WB_ARB_HAZARD_EN
      test_hazard();
`endif
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/riscv_wb_arbiter.md
Name: riscv_wb_arbiter

Overview:
- Shares the single register-file write port between two requesters:
  - the in-order pipeline writeback stage (W);
  - a long-latency auxiliary result source (multi-cycle divider / late load).
- Aux results are buffered in a small FIFO.
- Pipeline writes have priority; a starvation counter forces an aux write by stalling W.
- Sits between the writeback mux and the register file.

Parameters:
- DEPTH, 4, aux FIFO entries (power of 2, >=2)
- STARVE_LIMIT, 4, consecutive cycles a valid FIFO head may lose arbitration before it is forced (>=1)

Ports:
- i_clk  in  1  clock, rising edge
- i_rst  in  1  asynchronous, active-high reset
- i_wb_we  in  1  pipeline W-stage write request
- i_wb_rd_addr  in  5  pipeline destination register
- i_wb_rd_data  in  XLEN  pipeline result
- o_wb_stall  out  1  pipeline write not performed this cycle; W must hold and re-present next cycle
- i_aux_valid  in  1  aux result offered
- o_aux_ready  out  1  FIFO can accept (a transfer occurs when valid&ready)
- i_aux_rd_addr  in  5  aux destination register
- i_aux_rd_data  in  XLEN  aux result
- o_rf_we  out  1  register-file write enable
- o_rf_rd_addr  out  5  register-file write address
- o_rf_rd_data  out  XLEN  register-file write data
- o_aux_count  out  clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (i_rst high, async): FIFO pointers and count = 0, starve_cnt = 0.
  - Outputs while in reset: o_rf_we=0, o_wb_stall=0, o_aux_ready=0, o_rf_rd_addr=0, o_rf_rd_data=0, o_aux_count=0.
  - Reset mid-operation discards all buffered aux results with no write.
- Write port outputs are combinational from the current inputs and the FIFO head (0-cycle latency for pipeline writes).
- Aux latency is at least 1 cycle: results always pass through the FIFO; there is no same-cycle bypass.
- Definitions:
  - wb_req = i_wb_we & (i_wb_rd_addr != 0)
  - head_v = (count != 0)
- Grant, evaluated every cycle:
  - grant_aux = head_v & (!wb_req | starve_cnt == STARVE_LIMIT)
  - grant_wb = wb_req & !grant_aux
- Outputs from the grant:
  - grant_aux: o_rf_we=1, addr/data = FIFO head; the head pops at the clock edge.
  - grant_wb: o_rf_we=1, addr/data = pipeline inputs.
  - Neither: o_rf_we=0, addr/data=0.
  - o_wb_stall = wb_req & grant_aux.
- Pipeline write to x0 is never forwarded and never stalled.
- starve_cnt:
  - cleared when head_v=0 or grant_aux;
  - else incremented when head_v & grant_wb;
  - saturates at STARVE_LIMIT.
- FIFO:
  - o_aux_ready = (count < DEPTH); registered-state only, no combinational path from pop.
  - Accepted aux results with rd=0 are consumed and discarded (not stored).
  - Simultaneous push and pop: count unchanged.
  - Full: ready=0, so valid must hold.
  - Pointers wrap modulo DEPTH.
- Ordering guarantee: aux results write in acceptance order. WAW/RAW against pending aux entries is resolved by the hazard unit, not here.

Optional Feature:
- Macro: RISCV_WB_ARB_HAZARD_EN
- Defined: adds ports
  - i_rs1_addrD in 5
  - i_rs2_addrD in 5
  - i_rd_addrD in 5
  - o_aux_hazard out 1
- o_aux_hazard is combinational: 1 when any valid FIFO entry, or an accepting aux transfer this cycle, has rd equal to any of the three nonzero decode addresses.
- Its value is 0 in reset and 0 when the FIFO is empty with no transfer.
- Not defined: ports and comparators are absent; behaviour is otherwise identical.

Decomposition:
- `XLEN comes from the shared riscv_configs.v.
- Add to riscv_configs.v: `RF_ADDR_W (5) and the default DEPTH/STARVE_LIMIT values.
- One sub-module: riscv_wb_fifo (parameterised sync FIFO with DEPTH, XLEN+5 data, count output, plus per-entry valid/rd vectors for the hazard compare).
- Arbitration, starve counter and output mux stay in riscv_wb_arbiter.

Test Plan:
- Reset, then idle; pulse i_rst during activity:
  - idle: all outputs 0;
  - after the pulse: count=0 and no write of the flushed entries.
- Pipeline only: we=1, rd=5, data=0x11 -> same-cycle o_rf_we=1, addr 5, data 0x11, stall=0. With rd=0 -> o_rf_we=0.
- Aux into an idle pipeline: push rd=7, data=0xAA at cycle t -> o_rf_we=1, addr 7 at t+1; count back to 0 at t+2.
- Starvation: one aux entry plus continuous pipeline writes, STARVE_LIMIT=4:
  - pipeline wins 4 cycles;
  - 5th cycle: aux writes, o_wb_stall=1;
  - 6th cycle: held pipeline write completes.
- Full FIFO: push 4 entries during continuous pipeline writes -> o_aux_ready=0 with count=4. A push and a pop in the same cycle -> count unchanged. Pops occur in order of acceptance.
- Hazard (macro defined): FIFO holds rd=9, i_rs2_addrD=9 -> o_aux_hazard=1. Same with rd=0 -> 0. After the entry pops -> 0.
